// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- control-side pipeline for a D/E/M/W in-order core.
//
// Purpose:
//   Carries decode-stage control bits and register indices through the
//   E, M and W stages. Detects load-use hazards, inserts bubbles on a taken
//   branch or a hazard, freezes the whole pipe while data memory is busy,
//   and produces the operand-forwarding selects for the execute stage.
//
// Ports:
//   clk, reset             rising-edge clock; asynchronous active-high reset
//   *D inputs              decode-stage controls, validD, rs1D/rs2D/rdD
//   FlushE                 taken branch: instruction entering E becomes a bubble
//   MemBusy                data memory not ready: freeze E/M/W
//   StallD                 hold fetch/decode this cycle
//   *E outputs             execute-stage controls, indices and validE
//   *M outputs             memory-stage controls and rdM
//   *W outputs             writeback-stage controls and rdW
//   ForwardAE, ForwardBE   00 regfile, 01 W result, 10 M result
module ctrl_pipe #(
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RegWriteD,
  input  logic          MemWriteD,
  input  logic          LoadD,
  input  logic          ByteD,
  input  logic          ALUSrcD,
  input  logic          MemtoRegD,
  input  logic [2:0]    ALUControlD,
  input  logic          validD,
  input  logic [RW-1:0] rs1D,
  input  logic [RW-1:0] rs2D,
  input  logic [RW-1:0] rdD,
  input  logic          FlushE,
  input  logic          MemBusy,
  output logic          StallD,
  output logic          RegWriteE,
  output logic          MemWriteE,
  output logic          LoadE,
  output logic          ByteE,
  output logic          ALUSrcE,
  output logic          MemtoRegE,
  output logic [2:0]    ALUControlE,
  output logic [RW-1:0] rs1E,
  output logic [RW-1:0] rs2E,
  output logic [RW-1:0] rdE,
  output logic          validE,
  output logic          RegWriteM,
  output logic          MemWriteM,
  output logic          ByteM,
  output logic          MemtoRegM,
  output logic [RW-1:0] rdM,
  output logic          RegWriteW,
  output logic          ByteW,
  output logic          MemtoRegW,
  output logic [RW-1:0] rdW,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE
);

  logic hz;
  logic e_take;

  // Load in E whose destination is read by the instruction sitting in D.
  always_comb begin
    hz = validE & LoadE & (rdE != '0) & validD & ((rdE == rs1D) | (rdE == rs2D));
  end

  assign StallD = MemBusy | hz;

  // D is captured into E only for a real instruction that is neither
  // squashed by a branch nor held back by a load-use hazard; anything else
  // becomes an all-zero bubble.
  assign e_take = validD & ~FlushE & ~hz;

  // D -> E
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      LoadE       <= 1'b0;
      ByteE       <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemtoRegE   <= 1'b0;
      ALUControlE <= '0;
      rs1E        <= '0;
      rs2E        <= '0;
      rdE         <= '0;
      validE      <= 1'b0;
    end else if (!MemBusy) begin
      // x0 is hard-wired zero, so a write to it is dropped here and never
      // becomes a forwarding source.
      RegWriteE   <= e_take & RegWriteD & (rdD != '0);
      MemWriteE   <= e_take & MemWriteD;
      LoadE       <= e_take & LoadD;
      ByteE       <= e_take & ByteD;
      ALUSrcE     <= e_take & ALUSrcD;
      MemtoRegE   <= e_take & MemtoRegD;
      ALUControlE <= e_take ? ALUControlD : 3'b000;
      rs1E        <= e_take ? rs1D : '0;
      rs2E        <= e_take ? rs2D : '0;
      rdE         <= e_take ? rdD : '0;
      validE      <= e_take;
    end
  end

  // E -> M, with every control qualified by validE so a bubble stays inert.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      ByteM     <= 1'b0;
      MemtoRegM <= 1'b0;
      rdM       <= '0;
    end else if (!MemBusy) begin
      RegWriteM <= validE & RegWriteE;
      MemWriteM <= validE & MemWriteE;
      ByteM     <= validE & ByteE;
      MemtoRegM <= validE & MemtoRegE;
      rdM       <= validE ? rdE : '0;
    end
  end

  // M -> W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteW <= 1'b0;
      ByteW     <= 1'b0;
      MemtoRegW <= 1'b0;
      rdW       <= '0;
    end else if (!MemBusy) begin
      RegWriteW <= RegWriteM;
      ByteW     <= ByteM;
      MemtoRegW <= MemtoRegM;
      rdW       <= rdM;
    end
  end

  // Forwarding: one identical unit per source operand. M is younger than W,
  // so it wins when both match.
  logic [RW-1:0] rs_e [2];
  logic [1:0]    fwd  [2];

  assign rs_e[0] = rs1E;
  assign rs_e[1] = rs2E;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd[gi] = 2'b00;
        if (RegWriteM && (rdM != '0) && (rdM == rs_e[gi])) begin
          fwd[gi] = 2'b10;
        end else if (RegWriteW && (rdW != '0) && (rdW == rs_e[gi])) begin
          fwd[gi] = 2'b01;
        end
      end
    end
  endgenerate

  assign ForwardAE = fwd[0];
  assign ForwardBE = fwd[1];

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe -- directed self-checking bench for ctrl_pipe.
// An instruction-record model tracks which instruction occupies E, M and W;
// a negedge process compares every DUT output against it, and the directed
// scenarios add hand-computed literal expectations.
module tb_ctrl_pipe;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mw;
    logic       ld;
    logic       by;
    logic       as;
    logic       mr;
    logic [2:0] alu;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ins_t;

  logic clk = 1'b0;
  logic reset;
  ins_t d_in;
  logic flush;
  logic busy;

  logic       StallD;
  logic       RegWriteE, MemWriteE, LoadE, ByteE, ALUSrcE, MemtoRegE, validE;
  logic [2:0] ALUControlE;
  logic [4:0] rs1E, rs2E, rdE;
  logic       RegWriteM, MemWriteM, ByteM, MemtoRegM;
  logic [4:0] rdM;
  logic       RegWriteW, ByteW, MemtoRegW;
  logic [4:0] rdW;
  logic [1:0] ForwardAE, ForwardBE;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ctrl_pipe #(.RW(5)) dut (
    .clk(clk), .reset(reset),
    .RegWriteD(d_in.rw), .MemWriteD(d_in.mw), .LoadD(d_in.ld), .ByteD(d_in.by),
    .ALUSrcD(d_in.as), .MemtoRegD(d_in.mr), .ALUControlD(d_in.alu),
    .validD(d_in.v), .rs1D(d_in.rs1), .rs2D(d_in.rs2), .rdD(d_in.rd),
    .FlushE(flush), .MemBusy(busy), .StallD(StallD),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .LoadE(LoadE), .ByteE(ByteE),
    .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE), .ALUControlE(ALUControlE),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .validE(validE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ByteM(ByteM),
    .MemtoRegM(MemtoRegM), .rdM(rdM),
    .RegWriteW(RegWriteW), .ByteW(ByteW), .MemtoRegW(MemtoRegW), .rdW(rdW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  // ---------------- model: which instruction is in which stage ----------
  ins_t me, mm, mw;

  function automatic ins_t mk(input int rd, input int rs1, input int rs2,
                              input bit rw, input bit ld, input bit st);
    ins_t r;
    r.v   = 1'b1;
    r.rw  = rw;
    r.mw  = st;
    r.ld  = ld;
    r.by  = ld & rd[0];
    r.as  = ld | st;
    r.mr  = ld;
    r.alu = rd[2:0];
    r.rs1 = rs1[4:0];
    r.rs2 = rs2[4:0];
    r.rd  = rd[4:0];
    return r;
  endfunction

  function automatic bit m_hz();
    return me.v && me.ld && me.rd != 0 && d_in.v &&
           (me.rd == d_in.rs1 || me.rd == d_in.rs2);
  endfunction

  // Architectural view of the instruction entering E: a real, unsquashed,
  // non-stalled instruction, with writes to x0 discarded; else nothing.
  function automatic ins_t enter_e(input ins_t d, input bit fl, input bit h);
    ins_t r;
    if (!d.v || fl || h) return '0;
    r = d;
    r.rw = d.rw && (d.rd != 0);
    return r;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (mm.v && mm.rw && mm.rd != 0 && mm.rd == rs) return 2'b10;
    if (mw.v && mw.rw && mw.rd != 0 && mw.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      me <= '0;
      mm <= '0;
      mw <= '0;
    end else if (!busy) begin
      mw <= mm;
      mm <= me;
      me <= enter_e(d_in, flush, m_hz());
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("StallD",    int'(StallD),      int'(busy | m_hz()));
      cmp("validE",    int'(validE),      int'(me.v));
      cmp("RegWriteE", int'(RegWriteE),   int'(me.rw));
      cmp("MemWriteE", int'(MemWriteE),   int'(me.mw));
      cmp("LoadE",     int'(LoadE),       int'(me.ld));
      cmp("ByteE",     int'(ByteE),       int'(me.by));
      cmp("ALUSrcE",   int'(ALUSrcE),     int'(me.as));
      cmp("MemtoRegE", int'(MemtoRegE),   int'(me.mr));
      cmp("ALUCtlE",   int'(ALUControlE), int'(me.alu));
      cmp("rs1E",      int'(rs1E),        int'(me.rs1));
      cmp("rs2E",      int'(rs2E),        int'(me.rs2));
      cmp("rdE",       int'(rdE),         int'(me.rd));
      cmp("RegWriteM", int'(RegWriteM),   int'(mm.v & mm.rw));
      cmp("MemWriteM", int'(MemWriteM),   int'(mm.v & mm.mw));
      cmp("ByteM",     int'(ByteM),       int'(mm.v & mm.by));
      cmp("MemtoRegM", int'(MemtoRegM),   int'(mm.v & mm.mr));
      cmp("rdM",       int'(rdM),         int'(mm.rd));
      cmp("RegWriteW", int'(RegWriteW),   int'(mw.v & mw.rw));
      cmp("ByteW",     int'(ByteW),       int'(mw.v & mw.by));
      cmp("MemtoRegW", int'(MemtoRegW),   int'(mw.v & mw.mr));
      cmp("rdW",       int'(rdW),         int'(mw.rd));
      cmp("ForwardAE", int'(ForwardAE),   int'(m_fwd(me.rs1)));
      cmp("ForwardBE", int'(ForwardBE),   int'(m_fwd(me.rs2)));
    end
  end

  // Inputs change 2 time units after the active edge; literal checks follow #1.
  task automatic drive(input ins_t d, input bit fl, input bit bz);
    @(posedge clk);
    #2;
    d_in  = d;
    flush = fl;
    busy  = bz;
  endtask

  localparam ins_t NOP = '0;

  initial begin
    reset = 1'b1;
    d_in  = '0;
    flush = 1'b0;
    busy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_validE",    int'(validE),    0);
    cmp("rst_RegWriteW", int'(RegWriteW), 0);
    cmp("rst_StallD",    int'(StallD),    0);
    cmp("rst_ForwardAE", int'(ForwardAE), 0);
    cmp("rst_rdM",       int'(rdM),       0);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // Back-to-back dependency: M forwarding.
    drive(mk(5, 1, 2, 1, 0, 0), 0, 0);
    drive(mk(6, 5, 3, 1, 0, 0), 0, 0);
    drive(NOP, 0, 0);
    #1 cmp("b2b_ForwardAE", int'(ForwardAE), 2);
    // One instruction apart: W forwarding.
    drive(mk(8, 1, 2, 1, 0, 0), 0, 0);
    drive(NOP, 0, 0);
    drive(mk(9, 8, 4, 1, 0, 0), 0, 0);
    drive(NOP, 0, 0);
    #1 cmp("gap_ForwardAE", int'(ForwardAE), 1);

    // Load-use: one stall cycle, bubble, then W forwarding on rs2.
    drive(mk(7, 1, 1, 1, 1, 0), 0, 0);
    drive(mk(10, 0, 7, 1, 0, 0), 0, 0);
    #1 cmp("lu_StallD", int'(StallD), 1);
    drive(mk(10, 0, 7, 1, 0, 0), 0, 0);
    #1;
    cmp("lu_bubble_validE", int'(validE), 0);
    cmp("lu_stall_over",    int'(StallD), 0);
    drive(NOP, 0, 0);
    #1 cmp("lu_ForwardBE", int'(ForwardBE), 1);

    // rd = x0 load: never written, never a hazard.
    drive(mk(0, 3, 3, 1, 1, 0), 0, 0);
    drive(mk(4, 0, 0, 1, 0, 0), 0, 0);
    #1;
    cmp("x0_RegWriteE", int'(RegWriteE), 0);
    cmp("x0_StallD",    int'(StallD),    0);
    drive(NOP, 0, 0);
    #1 cmp("x0_ForwardAE", int'(ForwardAE), 0);

    // Flush coinciding with a load-use hazard.
    drive(mk(11, 1, 2, 1, 1, 0), 0, 0);
    drive(mk(12, 11, 0, 1, 0, 0), 1, 0);
    #1 cmp("fl_StallD", int'(StallD), 1);
    drive(mk(12, 11, 0, 1, 0, 0), 0, 0);
    #1;
    cmp("fl_validE",    int'(validE),    0);
    cmp("fl_RegWriteM", int'(RegWriteM), 1);
    cmp("fl_rdM",       int'(rdM),       11);
    drive(NOP, 0, 0);
    #1 cmp("fl_ForwardAE", int'(ForwardAE), 1);

    // Three-cycle memory freeze with a full pipe, plus a store in flight.
    drive(mk(13, 1, 2, 1, 0, 0), 0, 0);
    drive(mk(14, 3, 4, 1, 0, 0), 0, 0);
    drive(mk(15, 14, 13, 0, 0, 1), 0, 0);
    drive(NOP, 0, 1);
    #1;
    cmp("bz0_rdE", int'(rdE), 15);
    cmp("bz0_rdW", int'(rdW), 13);
    drive(NOP, 0, 1);
    drive(NOP, 0, 1);
    #1;
    cmp("bz2_rdE",       int'(rdE),       15);
    cmp("bz2_rdM",       int'(rdM),       14);
    cmp("bz2_rdW",       int'(rdW),       13);
    cmp("bz2_StallD",    int'(StallD),    1);
    cmp("bz2_ForwardAE", int'(ForwardAE), 2);
    cmp("bz2_ForwardBE", int'(ForwardBE), 1);
    drive(NOP, 0, 0);
    #1 cmp("bz3_rdM", int'(rdM), 14);
    drive(NOP, 0, 0);
    #1;
    cmp("rs_rdM",      int'(rdM),       15);
    cmp("rs_MemWrM",   int'(MemWriteM), 1);
    cmp("rs_rdW",      int'(rdW),       14);
    cmp("rs_validE",   int'(validE),    0);

    // Asynchronous reset during a freeze.
    drive(mk(16, 1, 2, 1, 0, 0), 0, 0);
    drive(NOP, 0, 0);
    drive(mk(17, 2, 3, 1, 0, 0), 0, 0);
    drive(NOP, 0, 1);
    #1;
    cmp("pre_RegWriteW", int'(RegWriteW), 1);
    cmp("pre_validE",    int'(validE),    1);
    reset = 1'b1;
    #1;
    cmp("ar_RegWriteW", int'(RegWriteW), 0);
    cmp("ar_validE",    int'(validE),    0);
    cmp("ar_rdW",       int'(rdW),       0);
    reset = 1'b0;
    drive(mk(18, 1, 2, 1, 0, 0), 0, 0);
    drive(NOP, 0, 0);
    #1;
    cmp("post_validE", int'(validE), 1);
    cmp("post_rdE",    int'(rdE),    18);

    repeat (3) drive(NOP, 0, 0);
    @(posedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
